push_button_debouncer: RTL and testbench

PUSH_BUTTON_DEBOUNCER -- requirements
Module: push_button_debouncer

---
 rtl/push_button_debouncer_if.sv | 22 ++
 rtl/push_button_debouncer.sv | 127 ++++++++++++
 tb/tb_push_button_debouncer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/push_button_debouncer_if.sv
// Button-side signal bundle for push_button_debouncer: raw level in,
// debounced level and press/release strobes out.
interface push_button_debouncer_if;
  logic button;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (
    output button,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  button,
    output btn_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/push_button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, 4-state stability FSM, registered
// level and press/release strobes. Define DEBOUNCE_RELEASE_PULSE_EN to build the release strobe.
module push_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  push_button_debouncer_if.slave btn
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             btn_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn.button;
      sync2_q <= sync1_q;
    end
  end

  assign btn_sync = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // A sample that disagrees with the pending level drops the count back to the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
  assign press_d = (state_q == WAIT_PRESS) && (state_d == PRESSED);

  assign btn.btn_level   = level_q;
  assign btn.press_pulse = press_q;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic release_q, release_d;

  assign release_d = (state_q == WAIT_RELEASE) && (state_d == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end

  assign btn.release_pulse = release_q;
`else
  assign btn.release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_push_button_debouncer.sv
// Bench for push_button_debouncer (DEBOUNCE_CYCLES=4): directed scenarios plus
// random button traffic compared against a run-length reference model.
module tb_push_button_debouncer;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  push_button_debouncer_if bif ();

  push_button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the FSM sees the button as it was two edges earlier; the
  // accepted level flips once D consecutive seen samples disagree with it.
  logic m_s1, m_s2, m_level, exp_press, exp_rel;
  int   m_run;

  function automatic void model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
    exp_press = 1'b0; exp_rel = 1'b0;
  endfunction

  function automatic void model_edge();
    logic s;
    if (!rst) begin
      model_reset();
      return;
    end
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = bif.button;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_run   = 0;
        if (s) exp_press = 1'b1;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        else exp_rel = 1'b1;
`endif
      end
    end else begin
      m_run = 0;
    end
  endfunction

  task automatic tick(input logic b);
    bif.button = b;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int press_edge, press_cnt;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1);
      n_chk++;
      if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000)
        $display("FAIL reset_outputs cyc %0d: got %b expected 000", i,
                 {bif.btn_level, bif.press_pulse, bif.release_pulse});
      else n_pass++;
    end
    rst = 1'b1;
    press_edge = 0; press_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      if (bif.press_pulse === 1'b1) begin press_cnt++; press_edge = i; end
      n_chk++;
      if (bif.press_pulse !== exp_press)
        $display("FAIL reset_press cyc %0d: got %b expected %b", i, bif.press_pulse, exp_press);
      else n_pass++;
      n_chk++;
      if (bif.btn_level !== m_level)
        $display("FAIL reset_level cyc %0d: got %b expected %b", i, bif.btn_level, m_level);
      else n_pass++;
    end
    n_chk++;
    if (press_edge !== 6 || press_cnt !== 1)
      $display("FAIL reset_press_timing: got edge %0d count %0d expected edge 6 count 1", press_edge, press_cnt);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0);
      n_chk++;
      if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== {m_level, exp_press, exp_rel})
        $display("FAIL press_prep cyc %0d: got %b expected %b", i,
                 {bif.btn_level, bif.press_pulse, bif.release_pulse}, {m_level, exp_press, exp_rel});
      else n_pass++;
    end
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1);
      n_chk++;
      if (bif.press_pulse !== (i == 6) || bif.btn_level !== (i >= 6) || bif.release_pulse !== 1'b0)
        $display("FAIL clean_press cyc %0d: got lvl %b press %b rel %b expected lvl %b press %b rel 0",
                 i, bif.btn_level, bif.press_pulse, bif.release_pulse, (i >= 6), (i == 6));
      else n_pass++;
      n_chk++;
      if ({bif.btn_level, bif.press_pulse} !== {m_level, exp_press})
        $display("FAIL clean_press_model cyc %0d: got %b expected %b", i,
                 {bif.btn_level, bif.press_pulse}, {m_level, exp_press});
      else n_pass++;
    end
  endtask

  task automatic test_release_glitch();
    for (int i = 1; i <= 14; i++) begin
      tick((i <= 2) ? 1'b0 : 1'b1);
      n_chk++;
      if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b100)
        $display("FAIL release_glitch cyc %0d: got %b expected 100", i,
                 {bif.btn_level, bif.press_pulse, bif.release_pulse});
      else n_pass++;
    end
  endtask

  task automatic test_clean_release();
    logic exp_r;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0);
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      exp_r = (i == 6);
`else
      exp_r = 1'b0;
`endif
      n_chk++;
      if (bif.btn_level !== (i < 6) || bif.release_pulse !== exp_r || bif.press_pulse !== 1'b0)
        $display("FAIL clean_release cyc %0d: got lvl %b rel %b press %b expected lvl %b rel %b press 0",
                 i, bif.btn_level, bif.release_pulse, bif.press_pulse, (i < 6), exp_r);
      else n_pass++;
      n_chk++;
      if (bif.release_pulse !== exp_rel)
        $display("FAIL clean_release_model cyc %0d: got %b expected %b", i, bif.release_pulse, exp_rel);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic b;
    for (int i = 1; i <= 16; i++) begin
      b = (i > 4) ? 1'b1 : ((i % 2) == 1);
      tick(b);
      n_chk++;
      if (bif.press_pulse !== (i == 10) || bif.btn_level !== (i >= 10))
        $display("FAIL bounce cyc %0d: got lvl %b press %b expected lvl %b press %b",
                 i, bif.btn_level, bif.press_pulse, (i >= 10), (i == 10));
      else n_pass++;
      n_chk++;
      if ({bif.btn_level, bif.press_pulse} !== {m_level, exp_press})
        $display("FAIL bounce_model cyc %0d: got %b expected %b", i,
                 {bif.btn_level, bif.press_pulse}, {m_level, exp_press});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    for (int i = 1; i <= 10; i++) tick(1'b0);
    n_chk++;
    if (bif.btn_level !== 1'b0)
      $display("FAIL mid_prep_level: got %b expected 0", bif.btn_level);
    else n_pass++;
    for (int i = 1; i <= 4; i++) tick(1'b1);
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== 3'b000)
      $display("FAIL mid_debounce_reset: got %b expected 000", {bif.btn_level, bif.press_pulse, bif.release_pulse});
    else n_pass++;
    tick(1'b1);
    tick(1'b1);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      n_chk++;
      if (bif.press_pulse !== (i == 6) || bif.btn_level !== (i >= 6))
        $display("FAIL requalify cyc %0d: got lvl %b press %b expected lvl %b press %b",
                 i, bif.btn_level, bif.press_pulse, (i >= 6), (i == 6));
      else n_pass++;
    end
    for (int i = 1; i <= 10; i++) tick(1'b0);
    for (int i = 1; i <= 6; i++) tick(1'b1);
    n_chk++;
    if (bif.press_pulse !== 1'b1)
      $display("FAIL mid_pulse_setup: got press %b expected 1", bif.press_pulse);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if ({bif.btn_level, bif.press_pulse} !== 2'b00)
      $display("FAIL mid_pulse_reset: got %b expected 00", {bif.btn_level, bif.press_pulse});
    else n_pass++;
    tick(1'b1);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      n_chk++;
      if (bif.press_pulse !== (i == 6))
        $display("FAIL held_after_reset cyc %0d: got %b expected %b", i, bif.press_pulse, (i == 6));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int cyc, last_press, len;
    logic v;
    cyc = 0;
    last_press = -1000;
    for (int seg = 0; seg < 300; seg++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * D + 2));
      for (int k = 0; k < len; k++) begin
        tick(v);
        cyc++;
        n_chk++;
        if ({bif.btn_level, bif.press_pulse, bif.release_pulse} !== {m_level, exp_press, exp_rel})
          $display("FAIL random cyc %0d: got %b expected %b", cyc,
                   {bif.btn_level, bif.press_pulse, bif.release_pulse}, {m_level, exp_press, exp_rel});
        else n_pass++;
        if (bif.press_pulse === 1'b1) begin
          n_chk++;
          if (bif.release_pulse !== 1'b0 || (cyc - last_press) < 2 * D)
            $display("FAIL random_pulse_rules cyc %0d: got rel %b gap %0d expected rel 0 gap >= %0d",
                     cyc, bif.release_pulse, cyc - last_press, 2 * D);
          else n_pass++;
          last_press = cyc;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bif.button = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_clean_release();
    test_bounce();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_chk);
    $fatal(1);
  end
endmodule
